seq_sort_cg: RTL and testbench



---
 rtl/seq_sort_pkg.sv | 25 ++
 rtl/cg_cell.sv | 19 +
 rtl/seq_sort_cg.sv | 238 +++++++++++++++++++++++
 tb/tb_seq_sort_cg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_sort_pkg.sv
// Shared definitions for the seq_sort_cg burst processor: mode codes,
// control FSM states and the counter-width helper.
package seq_sort_pkg;

    // Operation codes carried on in_mode; 6 and 7 fall back to pass-through.
    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_REV  = 3'd1;
    localparam logic [2:0] MODE_ASC  = 3'd2;
    localparam logic [2:0] MODE_DESC = 3'd3;
    localparam logic [2:0] MODE_PSUM = 3'd4;
    localparam logic [2:0] MODE_NORM = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Width of a counter able to hold 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cg_cell.sv
// Latch-based integrated clock gate: enable is captured while clk is low so
// the gated clock never glitches. test_en forces the clock on.
module cg_cell (
    input  logic clk,
    input  logic en,
    input  logic test_en,
    output logic gclk
);

    logic en_l;

    // Transparent-low enable latch.
    always_latch begin
        if (!clk) en_l <= en | test_en;
    end

    assign gclk = clk & en_l;

endmodule

// File: rtl/seq_sort_cg.sv
// seq_sort_cg: captures a burst of up to DEPTH unsigned words, runs the
// operation selected by in_mode for exactly DEPTH cycles, then streams DEPTH
// results. Latency is fixed from the last stored word whether the burst is
// full or short.
// Build option: define SEQ_SORT_CG_GATED_CLK_EN to clock the buffer/datapath
// registers through cg_cell (gated by cg_en); otherwise cg_en is ignored and
// plain register enables are used.
module seq_sort_cg
    import seq_sort_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cg_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DEPTH-1:0][WIDTH-1:0]  buf_q, buf_d;
    logic [2:0]                   mode_q, mode_d;
    logic                         out_valid_q, out_valid_d;
    logic [WIDTH-1:0]             out_data_q, out_data_d;

    logic                         cap_first, cap, phase_en;
    logic [CNT_W-1:0]             phase_cnt;
    logic [IDX_W-1:0]             idx;
    logic [DEPTH-1:0][WIDTH-1:0]  swp, xform;
    logic                         is_sort;

    // cnt_q is the store index in LOAD, the phase number in CALC and the
    // read index in OUT.
    assign idx     = cnt_q[IDX_W-1:0];
    assign is_sort = (mode_q == MODE_ASC) || (mode_q == MODE_DESC);

    // Control FSM: next state, counter and datapath strobes.
    // A short burst is detected one cycle late (in_valid low in LOAD); that
    // cycle already runs phase 0 so the overall latency matches a full burst.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_first = 1'b0;
        cap       = 1'b0;
        phase_en  = 1'b0;
        phase_cnt = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cap_first = 1'b1;
                    state_d   = LOAD;
                    cnt_d     = ONE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cap = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = CALC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    phase_en = 1'b1;
                    state_d  = CALC;
                    cnt_d    = ONE;
                end
            end
            CALC: begin
                phase_en  = 1'b1;
                phase_cnt = cnt_q;
                if (cnt_q == LAST) begin
                    state_d = OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            OUT: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and counter registers, always on the free-running clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One odd-even transposition phase: even phases pair (0,1),(2,3)..,
    // odd phases pair (1,2),(3,4)..; pairs are disjoint so reading buf_q is safe.
    always_comb begin
        swp = buf_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i[0] == phase_cnt[0]) begin
                if (((mode_q == MODE_ASC)  && (buf_q[i] > buf_q[i+1])) ||
                    ((mode_q == MODE_DESC) && (buf_q[i] < buf_q[i+1]))) begin
                    swp[i]   = buf_q[i+1];
                    swp[i+1] = buf_q[i];
                end
            end
        end
    end

    // Whole-buffer transforms for the non-sort modes, applied once at phase 0;
    // remaining CALC cycles just hold the result to keep latency fixed.
    always_comb begin
        logic [WIDTH-1:0] mn;
        logic [WIDTH:0]   acc;
        xform = buf_q;
        mn    = buf_q[0];
        acc   = '0;
        case (mode_q)
            MODE_REV: begin
                for (int i = 0; i < DEPTH; i++) xform[i] = buf_q[DEPTH-1-i];
            end
            MODE_PSUM: begin
                for (int i = 0; i < DEPTH; i++) begin
                    acc      = {1'b0, acc[WIDTH-1:0]} + {1'b0, buf_q[i]};
                    xform[i] = acc[WIDTH-1:0];
                end
            end
            MODE_NORM: begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (buf_q[i] < mn) mn = buf_q[i];
                end
                for (int i = 0; i < DEPTH; i++) xform[i] = buf_q[i] - mn;
            end
            default: ;
        endcase
    end

    // Buffer next value: clear-and-capture on the first word so short bursts
    // see zeros in unfilled slots, then store or compute.
    always_comb begin
        buf_d  = buf_q;
        mode_d = mode_q;
        if (cap_first) begin
            buf_d    = '0;
            buf_d[0] = in_data;
            mode_d   = in_mode;
        end else if (cap) begin
            buf_d[idx] = in_data;
        end else if (phase_en) begin
            if (is_sort)               buf_d = swp;
            else if (phase_cnt == '0)  buf_d = xform;
        end
    end

`ifdef SEQ_SORT_CG_GATED_CLK_EN
    logic dp_en, dp_clk;

    // Clock runs for LOAD/CALC/OUT and for the IDLE edge that captures word 0.
    assign dp_en = !cg_en || (state_q != IDLE) || in_valid;

    cg_cell u_cg_cell (
        .clk     (clk),
        .en      (dp_en),
        .test_en (1'b0),
        .gclk    (dp_clk)
    );

    // Buffer and mode registers on the gated clock.
    always_ff @(posedge dp_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            mode_q <= MODE_PASS;
        end else begin
            buf_q  <= buf_d;
            mode_q <= mode_d;
        end
    end
`else
    logic dp_we;
    logic unused_cg_en;

    assign dp_we        = cap_first | cap | phase_en;
    assign unused_cg_en = cg_en;

    // Buffer and mode registers with a plain write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            mode_q <= MODE_PASS;
        end else if (dp_we) begin
            buf_q  <= buf_d;
            mode_q <= mode_d;
        end
    end
`endif

    // Output stage: registered copy of the OUT-state read, forced to 0 otherwise.
    always_comb begin
        out_valid_d = (state_q == OUT);
        out_data_d  = (state_q == OUT) ? buf_q[idx] : '0;
    end

    // Output registers on the free-running clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_seq_sort_cg.sv
// Self-checking bench for seq_sort_cg: directed cases plus random bursts,
// compared against a behavioural model working on plain integer arrays.
module tb_seq_sort_cg;

    localparam int WIDTH = 9;
    localparam int DEPTH = 6;
    localparam int MAXN  = DEPTH + 2;

    logic             clk;
    logic             rst_n;
    logic             cg_en;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int stim [MAXN];
    int expv [DEPTH];

    seq_sort_cg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cg_en     (cg_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // Reference: take the first min(n,DEPTH) words, zero-fill, apply the mode.
    task automatic model(input int n, input int mode);
        int v [DEPTH];
        int m, s, mn, t;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < DEPTH; i++) v[i] = (i < m) ? stim[i] : 0;
        case (mode)
            1: for (int i = 0; i < DEPTH; i++) expv[i] = v[DEPTH-1-i];
            2, 3: begin
                for (int i = 0; i < DEPTH; i++) expv[i] = v[i];
                for (int i = 0; i < DEPTH; i++)
                    for (int j = i + 1; j < DEPTH; j++)
                        if ((mode == 2) ? (expv[j] < expv[i]) : (expv[j] > expv[i])) begin
                            t = expv[i]; expv[i] = expv[j]; expv[j] = t;
                        end
            end
            4: begin
                s = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    s = (s + v[i]) % (1 << WIDTH);
                    expv[i] = s;
                end
            end
            5: begin
                mn = v[0];
                for (int i = 1; i < DEPTH; i++) if (v[i] < mn) mn = v[i];
                for (int i = 0; i < DEPTH; i++) expv[i] = v[i] - mn;
            end
            default: for (int i = 0; i < DEPTH; i++) expv[i] = v[i];
        endcase
    endtask

    // Drive n words, then check out_valid/out_data on every cycle relative to
    // the last stored edge k up to k+2*DEPTH+1. stop_c>0 ends early (reset test).
    // noise toggles in_valid/in_data while the block is busy.
    task automatic run_burst(input int n, input int mode, input bit noise, input int stop_c);
        int k, c, m;
        int ev, ed;
        model(n, mode);
        m = (n > DEPTH) ? DEPTH : n;
        k = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i][WIDTH-1:0];
            in_mode  = (i == 0) ? mode[2:0] : 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            if (i == m - 1) k = cyc;
        end
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        c = cyc - k;
        while (c < 2 * DEPTH + 1) begin
            @(posedge clk);
            @(negedge clk);
            c  = cyc - k;
            ev = (c >= DEPTH + 1 && c <= 2 * DEPTH) ? 1 : 0;
            ed = ev ? expv[c - DEPTH - 1] : 0;
            check($sformatf("valid m%0d n%0d c%0d", mode, n, c), int'(out_valid), ev);
            check($sformatf("data m%0d n%0d c%0d", mode, n, c), int'(out_data), ed);
            if (stop_c > 0 && c == stop_c) break;
            in_valid = (noise && c >= 1 && c <= 2 * DEPTH - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = WIDTH'($urandom);
            in_mode  = 3'($urandom_range(0, 7));
        end
        in_valid = 1'b0;
    endtask

    task automatic set6(input int a, input int b, input int c, input int d, input int e, input int f);
        stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d; stim[4] = e; stim[5] = f;
        stim[6] = 0; stim[7] = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cg_en    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = '0;
        #23;
        check("reset valid", int'(out_valid), 0);
        check("reset data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int g = 0; g < 2; g++) begin
            cg_en = g[0];
            set6(5, 300, 0, 511, 42, 7);
            run_burst(6, 2, 1'b0, 0);
            run_burst(6, 3, 1'b0, 0);
            run_burst(6, 1, 1'b0, 0);
            run_burst(6, 4, 1'b0, 0);
            run_burst(6, 0, 1'b1, 0);
            set6(10, 20, 15, 30, 12, 11);
            run_burst(6, 5, 1'b0, 0);
            run_burst(6, 6, 1'b1, 0);
            run_burst(6, 7, 1'b0, 0);
            // short burst
            set6(9, 1, 4, 0, 0, 0);
            run_burst(3, 2, 1'b0, 0);
            run_burst(1, 4, 1'b1, 0);
            // in_valid held past DEPTH: extra words ignored
            set6(3, 1, 4, 1, 5, 9);
            stim[6] = 2; stim[7] = 6;
            run_burst(8, 2, 1'b0, 0);
            // reset during the third output cycle
            set6(5, 300, 0, 511, 42, 7);
            run_burst(6, 2, 1'b0, DEPTH + 3);
            #1;
            rst_n = 1'b0;
            #1;
            check("abort valid", int'(out_valid), 0);
            check("abort data", int'(out_data), 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 2 * DEPTH + 2; i++) begin
                @(negedge clk);
                check($sformatf("post-abort valid %0d", i), int'(out_valid), 0);
            end
            run_burst(6, 3, 1'b0, 0);
        end

        for (int r = 0; r < 30; r++) begin
            cg_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < MAXN; i++) stim[i] = int'($urandom_range(0, (1 << WIDTH) - 1));
            run_burst(int'($urandom_range(1, MAXN)), int'($urandom_range(0, 7)), 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
